// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-rate helper, data width.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  // System clocks per serial bit (integer division).
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream from the UART receiver to the protocol frame parser.
interface uart_rx_if;

  logic                                 rx_byte_valid;
  logic [uart_pkg::UART_DATA_BITS-1:0]  rx_byte;
  logic                                 frame_err;
  logic                                 busy;

  modport master (
    output rx_byte_valid,
    output rx_byte,
    output frame_err,
    output busy
  );

  modport slave (
    input rx_byte_valid,
    input rx_byte,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the raw input through two flops; reset loads the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification, mid-bit sampling, framing check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned N     = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned H     = N / 2;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW    = UART_DATA_BITS;

  if (N < 4) begin : g_bad_rate
    $error("uart_rx: CLK_FREQ_HZ / BAUD must be at least 4");
  end

  logic           rx_s;
  uart_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [DW-1:0]  shift_q, shift_d;
  logic [DW-1:0]  byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           busy_q, busy_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and datapath: sample at mid start bit, then every N cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_W'(H - 1)) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(N - 1)) begin
          shift_d = {rx_s, shift_q[DW-1:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'(DW - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(N - 1)) begin
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The bit timer restarts on every state change.
    if (state_d != state_q) cnt_d = '0;

    busy_d = (state_d != IDLE);
  end

  assign bus.rx_byte_valid = valid_q;
  assign bus.rx_byte       = byte_q;
  assign bus.frame_err     = ferr_q;
  assign bus.busy          = busy_q;

endmodule
